// File: rtl/cmd_issue_queue.sv
// cmd_issue_queue: front-end command stage for the L1 cache model.
// Buffers trace commands in a circular FIFO, issues them one at a time to
// the cache over valid/ready and waits for the cache completion pulse before
// issuing the next. Splits the issued address into tag/index/offset for a
// 16384-set cache with 64-byte lines and keeps per-class statistics.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake; in_n code, in_addr byte address
//   out_valid/out_ready        issue handshake to the cache; out_n, out_addr
//   out_tag/out_index/out_offset  slices of out_addr
//   cache_done                 one-cycle completion pulse from the cache
//   cnt_read/write/snoop/err   saturating statistics counters
module cmd_issue_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_n,
  input  logic [31:0]      in_addr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_n,
  output logic [31:0]      out_addr,
  output logic [11:0]      out_tag,
  output logic [13:0]      out_index,
  output logic [5:0]       out_offset,
  input  logic             cache_done,
  output logic [CNT_W-1:0] cnt_read,
  output logic [CNT_W-1:0] cnt_write,
  output logic [CNT_W-1:0] cnt_snoop,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int unsigned N_W   = 4;
  localparam int unsigned A_W   = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [N_W-1:0] n;
    logic [A_W-1:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [N_W-1:0]   out_n_q, out_n_d;
  logic [A_W-1:0]   out_addr_q, out_addr_d;
  logic [CNT_W-1:0] cnt_read_q, cnt_read_d;
  logic [CNT_W-1:0] cnt_write_q, cnt_write_d;
  logic [CNT_W-1:0] cnt_snoop_q, cnt_snoop_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  logic legal_c;
  logic push_c;
  logic reject_c;
  logic pop_c;
  logic empty_c;
  logic issue_hs_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Codes 7 and 10..15 are dropped at the input and only counted as errors.
  always_comb begin
    legal_c = 1'b0;
    case (in_n)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  assign push_c     = in_valid && in_ready_q && legal_c;
  assign reject_c   = in_valid && in_ready_q && !legal_c;
  assign empty_c    = (occ_q == '0);
  assign issue_hs_c = out_valid_q && out_ready;

  // Issue FSM next state and output register loads.
  always_comb begin
    state_d    = state_q;
    out_n_d    = out_n_q;
    out_addr_d = out_addr_q;
    pop_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (out_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cache_done) begin
          if (!empty_c) begin
            pop_c   = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop_c) begin
      out_n_d    = mem_q[rd_ptr_q].n;
      out_addr_d = mem_q[rd_ptr_q].addr;
    end
    out_valid_d = (state_d == S_ISSUE);
  end

  // FIFO pointers and occupancy; in_ready follows the post-update occupancy
  // so it is valid for the next cycle without any same-cycle pop bypass.
  always_comb begin
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d      = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
    in_ready_d = (occ_d != OCC_W'(DEPTH));
  end

  // Statistics; a clear command on the issue handshake overrides everything.
  always_comb begin
    cnt_read_d  = cnt_read_q;
    cnt_write_d = cnt_write_q;
    cnt_snoop_d = cnt_snoop_q;
    cnt_err_d   = cnt_err_q;
    if (issue_hs_c) begin
      case (out_n_q)
        4'd0, 4'd2:             cnt_read_d  = sat_inc(cnt_read_q);
        4'd1:                   cnt_write_d = sat_inc(cnt_write_q);
        4'd3, 4'd4, 4'd5, 4'd6: cnt_snoop_d = sat_inc(cnt_snoop_q);
        default: ;
      endcase
    end
    if (reject_c) cnt_err_d = sat_inc(cnt_err_q);
    if (issue_hs_c && (out_n_q == 4'd8)) begin
      cnt_read_d  = '0;
      cnt_write_d = '0;
      cnt_snoop_d = '0;
      cnt_err_d   = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      out_addr_q  <= '0;
      cnt_read_q  <= '0;
      cnt_write_q <= '0;
      cnt_snoop_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      if (push_c) mem_q[wr_ptr_q] <= '{n: in_n, addr: in_addr};
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      out_addr_q  <= out_addr_d;
      cnt_read_q  <= cnt_read_d;
      cnt_write_q <= cnt_write_d;
      cnt_snoop_q <= cnt_snoop_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_n      = out_n_q;
  assign out_addr   = out_addr_q;
  assign out_tag    = out_addr_q[31:20];
  assign out_index  = out_addr_q[19:6];
  assign out_offset = out_addr_q[5:0];
  assign cnt_read   = cnt_read_q;
  assign cnt_write  = cnt_write_q;
  assign cnt_snoop  = cnt_snoop_q;
  assign cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Testbench for cmd_issue_queue: directed stimulus, expected issues queued
// into a scoreboard and checked by an independent monitor on each handshake.
module tb_cmd_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_n = '0;
  logic [31:0] in_addr = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_n;
  logic [31:0] out_addr;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic        cache_done;
  logic [31:0] cnt_read, cnt_write, cnt_snoop, cnt_err;

  typedef struct packed {
    logic [3:0]  n;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   auto_done = 1'b1;
  bit   hs_seen = 1'b0;
  int   done_reqs = 0;
  int   done_acks = 0;

  cmd_issue_queue #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_n(in_n), .in_addr(in_addr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .out_addr(out_addr),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .cache_done(cache_done),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_snoop(cnt_snoop), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] n);
    return (n <= 4'd6) || (n == 4'd8) || (n == 4'd9);
  endfunction

  // Monitor: a handshake seen here happens at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      hs_seen = rst_n && out_valid && out_ready;
      if (hs_seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue_n", 32'(out_n), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("issue_n", 32'(out_n), 32'(e.n));
          check("issue_addr", out_addr, e.addr);
          check("issue_tag", 32'(out_tag), 32'(e.addr[31:20]));
          check("issue_index", 32'(out_index), 32'(e.addr[19:6]));
          check("issue_offset", 32'(out_offset), 32'(e.addr[5:0]));
        end
      end
    end
  end

  // Cache model: completion the cycle after acceptance, or on explicit request.
  initial begin
    cache_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cache_done = (auto_done && hs_seen) || (done_reqs != done_acks);
      if (done_reqs != done_acks) done_acks++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one command for one cycle; called just after a rising edge.
  task automatic send(input logic [3:0] n, input logic [31:0] a, input bit exp_rdy);
    in_valid = 1'b1;
    in_n     = n;
    in_addr  = a;
    @(negedge clk);
    check("in_ready_at_push", 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy && is_legal(n)) exp_q.push_back('{n: n, addr: a});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int r, input int w, input int s, input int e);
    check({tag, "_cnt_read"},  cnt_read,  32'(r));
    check({tag, "_cnt_write"}, cnt_write, 32'(w));
    check({tag, "_cnt_snoop"}, cnt_snoop, 32'(s));
    check({tag, "_cnt_err"},   cnt_err,   32'(e));
  endtask

  initial begin
    logic [3:0]  fn [9];
    logic [31:0] fa [9];
    fn = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd0};
    for (int i = 0; i < 9; i++) fa[i] = 32'h1000_0040 * (i + 1) + 32'(i);

    // Reset values
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_n", 32'(out_n), 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_cnts("rst", 0, 0, 0, 0);

    // Single command latency and address split
    out_ready = 1'b1;
    send(4'd0, 32'hABCD_EF01, 1'b1);
    @(negedge clk);
    check("lat_valid_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_edge2", 32'(out_valid), 32'd1);
    check("lat_tag", 32'(out_tag), 32'h0000_0ABC);
    check("lat_index", 32'(out_index), 32'h0000_37BC);
    check("lat_offset", 32'(out_offset), 32'h0000_0001);
    @(negedge clk);
    check("lat_cnt_read", cnt_read, 32'd1);
    wait_drain("lat_drain");

    // Fill: one held in the output register, eight queued, tenth refused
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(fn[i], fa[i], 1'b1);
    send(4'd1, 32'hDEAD_BEEF, 1'b0);
    check("fill_head_valid", 32'(out_valid), 32'd1);
    check("fill_head_n", 32'(out_n), 32'(fn[0]));
    check("fill_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain("fill_drain");
    repeat (3) @(posedge clk);
    #1;
    check_cnts("fill", 3, 1, 4, 0);
    check("fill_in_ready_after", 32'(in_ready), 32'd1);

    // Illegal codes never issue
    do_reset();
    send(4'd7, 32'h0000_1111, 1'b1);
    send(4'd15, 32'h0000_2222, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("illegal_cnt_err", cnt_err, 32'd2);
    check("illegal_in_ready", 32'(in_ready), 32'd1);
    check("illegal_out_valid", 32'(out_valid), 32'd0);

    // Clear and print commands
    do_reset();
    send(4'd12, 32'h0, 1'b1);
    send(4'd2, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 3; i++) send(4'd1, 32'h2000_0000 + 32'(i * 64), 1'b1);
    wait_drain("clr_drain_w");
    check_cnts("pre_clear", 1, 3, 0, 1);
    send(4'd8, 32'h0000_0800, 1'b1);
    wait_drain("clr_drain_8");
    check_cnts("post_clear", 0, 0, 0, 0);
    send(4'd9, 32'h0000_0900, 1'b1);
    wait_drain("clr_drain_9");
    check_cnts("post_print", 0, 0, 0, 0);

    // Clear coinciding with a rejection: clear wins
    send(4'd13, 32'h0, 1'b1);
    check("coin_err_before", cnt_err, 32'd1);
    out_ready = 1'b0;
    send(4'd8, 32'h0000_0808, 1'b1);
    @(posedge clk);
    #1;
    check("coin_issue_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_n      = 4'd14;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("coin_cnt_err", cnt_err, 32'd0);
    wait_drain("coin_drain");

    // Completion gating in WAIT, and an ignored pulse in IDLE
    do_reset();
    auto_done = 1'b0;
    send(4'd0, 32'h3000_0000, 1'b1);
    send(4'd1, 32'h3000_0040, 1'b1);
    @(negedge clk);
    check("gate_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gate_wait_valid", 32'(out_valid), 32'd0);
    end
    check("gate_pending", 32'(exp_q.size()), 32'd1);
    done_reqs++;
    wait_drain("gate_drain");
    done_reqs++;
    repeat (3) @(posedge clk);
    #1;
    done_reqs++;
    repeat (3) @(posedge clk);
    #1;
    check("idle_pulse_valid", 32'(out_valid), 32'd0);
    check("idle_pulse_in_ready", 32'(in_ready), 32'd1);
    send(4'd3, 32'h3000_0080, 1'b1);
    @(negedge clk);
    check("idle_after_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("idle_after_edge2", 32'(out_valid), 32'd1);
    done_reqs++;
    wait_drain("idle_drain");

    // Reset mid-WAIT with three commands queued
    do_reset();
    for (int i = 0; i < 4; i++) send(4'd0, 32'h4000_0000 + 32'(i * 64), 1'b1);
    @(posedge clk);
    #3;
    check("mid_sb_left", 32'(exp_q.size()), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt_read", cnt_read, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    auto_done = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_issue", 32'(out_valid), 32'd0);
    send(4'd5, 32'h5555_5555, 1'b1);
    wait_drain("mid_drain");
    repeat (2) @(posedge clk);
    #1;
    check("mid_cnt_snoop", cnt_snoop, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
